// File: rtl/mux_fifo_pkg.sv
// mux_fifo_pkg: width helpers and shared types for mux_fifo.
// MUX_FIFO_PTR_W(d) gives the pointer width for a depth d.
// MUX_FIFO_CNT_W(d) gives the width of a count that can hold the value d itself.
`define MUX_FIFO_PTR_W(d) (mux_fifo_pkg::clog2(d))
`define MUX_FIFO_CNT_W(d) (mux_fifo_pkg::clog2(d) + 1)

package mux_fifo_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  typedef struct packed {
    logic overflow;
    logic underflow;
  } mux_fifo_err_t;
endpackage

// File: rtl/mux_fifo_mem.sv
// mux_fifo_mem: DEPTH x N register array with one write port and one asynchronous read port.
// Ports: clk; we/wa/wd write enable, address and data; ra/rd read address and data.
module mux_fifo_mem #(
  parameter int N = 32,
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] wa,
  input  logic [N-1:0]     wd,
  input  logic [PTR_W-1:0] ra,
  output logic [N-1:0]     rd
);
  logic [N-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  assign rd = mem[ra];
endmodule

// File: rtl/mux_fifo.sv
// mux_fifo: selects one of NUM_IN channels into a DEPTH-entry FIFO with status and sticky error flags.
// Ports: clk, rst (async, active high), clr (sync flush); in_data/in_sel/in_en write side;
// out_en pop; out/out_valid read data; full/empty/count occupancy; overflow/underflow sticky flags.
// Define MUX_FIFO_FWFT_EN for first-word fall-through output; otherwise the read is registered.
module mux_fifo
  import mux_fifo_pkg::*;
#(
  parameter int N = 32,
  parameter int NUM_IN = 2,
  parameter int DEPTH = 8,
  localparam int SEL_W = clog2(NUM_IN),
  localparam int CNT_W = `MUX_FIFO_CNT_W(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [NUM_IN*N-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_en,
  input  logic              out_en,
  output logic [N-1:0]      out,
  output logic              out_valid,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);
  localparam int PTR_W = `MUX_FIFO_PTR_W(DEPTH);
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [N-1:0] wdata, rdata;
  logic sel_ok, rd_ok, wr_ok;
  mux_fifo_err_t err;
  assign sel_ok = int'(in_sel) < NUM_IN;
  // Index clamped so an out-of-range select never reaches past the packed bus.
  assign wdata = in_data[(sel_ok ? int'(in_sel) : 0)*N +: N];
  assign empty = count == '0;
  assign full = count == CNT_W'(DEPTH);
  assign rd_ok = out_en & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign wr_ok = in_en & sel_ok & (~full | rd_ok);
  assign overflow = err.overflow;
  assign underflow = err.underflow;
  mux_fifo_mem #(.N(N), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
    .clk(clk),
    .we(wr_ok),
    .wa(wr_ptr),
    .wd(wdata),
    .ra(rd_ptr),
    .rd(rdata)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      err <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      err <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(wr_ok);
      rd_ptr <= rd_ptr + PTR_W'(rd_ok);
      count <= count + CNT_W'(wr_ok) - CNT_W'(rd_ok);
      err.overflow <= err.overflow | (in_en & sel_ok & full & ~rd_ok);
      err.underflow <= err.underflow | (out_en & empty);
    end
`ifdef MUX_FIFO_FWFT_EN
  assign out = empty ? '0 : rdata;
  assign out_valid = ~empty;
`else
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out <= '0;
      out_valid <= 1'b0;
    end else if (clr) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= rd_ok;
      if (rd_ok) out <= rdata;
    end
`endif
endmodule

// File: tb/tb_mux_fifo.sv
// tb_mux_fifo: directed and randomized checks of mux_fifo against a queue-based model.
module tb_mux_fifo;
  localparam int N = 32, NUM_IN = 5, DEPTH = 4, SEL_W = 3, CNT_W = 3;
  logic clk = 1'b0, rst, clr, in_en, out_en;
  logic [NUM_IN*N-1:0] in_data;
  logic [SEL_W-1:0] in_sel;
  logic [N-1:0] out;
  logic out_valid, full, empty, overflow, underflow;
  logic [CNT_W-1:0] count;
  int checks = 0, passed = 0;
  logic [N-1:0] q[$];
  logic [N-1:0] m_out;
  logic m_valid, m_ovf, m_unf;
  always #5 clk = ~clk;
  mux_fifo #(.N(N), .NUM_IN(NUM_IN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_data(in_data), .in_sel(in_sel), .in_en(in_en),
    .out_en(out_en), .out(out), .out_valid(out_valid), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic compare();
`ifdef MUX_FIFO_FWFT_EN
    chk("out", out, q.size() != 0 ? q[0] : '0);
    chk("out_valid", out_valid, q.size() != 0);
`else
    chk("out", out, m_out);
    chk("out_valid", out_valid, m_valid);
`endif
    chk("count", count, q.size());
    chk("full", full, q.size() == DEPTH);
    chk("empty", empty, q.size() == 0);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_unf);
  endtask
  task automatic model_reset();
    q.delete();
    m_out = '0;
    m_valid = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask
  task automatic set_ch(input int k, input logic [N-1:0] v);
    in_data[k*N +: N] = v;
  endtask
  // Drives one cycle of inputs (called at a falling edge), advances the model, checks after the edge.
  task automatic cycle(input logic ie, input logic [SEL_W-1:0] sel, input logic oe, input logic c = 1'b0);
    int n = q.size();
    logic rd, wr, ok;
    in_en = ie;
    in_sel = sel;
    out_en = oe;
    clr = c;
    ok = int'(sel) < NUM_IN;
    if (c) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_valid = 1'b0;
    end else begin
      rd = oe && n > 0;
      wr = ie && ok && (n < DEPTH || rd);
      if (ie && ok && n == DEPTH && !rd) m_ovf = 1'b1;
      if (oe && n == 0) m_unf = 1'b1;
      m_valid = rd;
      if (rd) m_out = q.pop_front();
      if (wr) q.push_back(in_data[int'(sel)*N +: N]);
    end
    @(negedge clk);
    compare();
    in_en = 1'b0;
    out_en = 1'b0;
    clr = 1'b0;
  endtask
  task automatic pop_expect(input logic [N-1:0] exp);
`ifdef MUX_FIFO_FWFT_EN
    chk("head", out, exp);
    chk("head_valid", out_valid, 1'b1);
    cycle(1'b0, '0, 1'b1);
`else
    cycle(1'b0, '0, 1'b1);
    chk("pop", out, exp);
    chk("pop_valid", out_valid, 1'b1);
`endif
  endtask
  initial begin
    rst = 1'b1;
    clr = 1'b0;
    in_en = 1'b0;
    out_en = 1'b0;
    in_sel = '0;
    in_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    compare();
    set_ch(0, 32'hA);
    cycle(1'b1, 3'd0, 1'b0);
    set_ch(0, 32'hB);
    cycle(1'b1, 3'd0, 1'b0);
    chk("pre_rst_count", count, 2);
    rst = 1'b1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_out", out, 0);
    chk("rst_valid", out_valid, 1'b0);
    model_reset();
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) set_ch(k, 32'h10 + k);
    cycle(1'b1, 3'd2, 1'b0);
    cycle(1'b1, 3'd0, 1'b0);
    cycle(1'b1, 3'd3, 1'b0);
    pop_expect(32'h12);
    pop_expect(32'h10);
    pop_expect(32'h13);
    for (int i = 1; i <= 5; i++) begin
      set_ch(0, i);
      cycle(1'b1, 3'd0, 1'b0);
      if (i == 4) chk("full_after_4", full, 1'b1);
    end
    chk("ovf_set", overflow, 1'b1);
    chk("count_full", count, 4);
    for (int i = 1; i <= 4; i++) pop_expect(i);
    chk("ovf_sticky", overflow, 1'b1);
    cycle(1'b0, 3'd0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      set_ch(0, i);
      cycle(1'b1, 3'd0, 1'b0);
    end
    set_ch(0, 32'd9);
    cycle(1'b1, 3'd0, 1'b1);
    chk("full_rw_count", count, 4);
    pop_expect(2);
    pop_expect(3);
    pop_expect(4);
    pop_expect(9);
    cycle(1'b0, 3'd0, 1'b1);
    chk("unf_set", underflow, 1'b1);
`ifndef MUX_FIFO_FWFT_EN
    chk("unf_out_hold", out, 9);
`endif
    set_ch(0, 32'd7);
    cycle(1'b1, 3'd0, 1'b1);
    chk("empty_rw_count", count, 1);
    pop_expect(7);
    for (int i = 0; i < 10; i++) begin
      set_ch(0, 32'h100 + i);
      cycle(1'b1, 3'd0, 1'b0);
      pop_expect(32'h100 + i);
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 3'd1, 1'b0);
    cycle(1'b1, 3'd1, 1'b0, 1'b1);
    chk("clr_count", count, 0);
    chk("clr_unf", underflow, 1'b0);
    cycle(1'b1, 3'd5, 1'b0);
    cycle(1'b1, 3'd7, 1'b0);
    chk("badsel_count", count, 0);
    chk("badsel_ovf", overflow, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < NUM_IN; k++) set_ch(k, $urandom);
      cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 49) == 0);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
